// File: rtl/noc_flit_tx_pkg.sv
// Shared flit and packet-header definitions for the NoC node injector
// and its matching receiver.
package noc_flit_tx_pkg;

    localparam int DATA_W    = 32;
    localparam int NODE_ID_W = 8;
    localparam int LEN_W     = 4;
    localparam int SEQ_W     = 8;

    localparam int HEAD_DST_LSB = 0;
    localparam int HEAD_SRC_LSB = 8;
    localparam int HEAD_LEN_LSB = 16;
    localparam int HEAD_SEQ_LSB = 20;

    typedef enum logic [1:0] {
        FLIT_HEAD = 2'd0,
        FLIT_BODY = 2'd1,
        FLIT_TAIL = 2'd2
    } flit_type_t;

    typedef logic [NODE_ID_W-1:0] node_id_t;

    typedef struct packed {
        flit_type_t        ftype;
        logic [DATA_W-1:0] data;
    } flit_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BODY = 2'd1,
        S_TAIL = 2'd2
    } tx_state_t;

endpackage

// File: rtl/noc_flit_tx_if.sv
// Node-side header/body inputs and the router-facing flit link.
interface noc_flit_tx_if
    import noc_flit_tx_pkg::*;
#(
    parameter int DATA_W    = noc_flit_tx_pkg::DATA_W,
    parameter int NODE_ID_W = noc_flit_tx_pkg::NODE_ID_W,
    parameter int LEN_W     = noc_flit_tx_pkg::LEN_W
);
    logic                 hdr_valid;
    logic                 hdr_ready;
    logic [NODE_ID_W-1:0] hdr_dst;
    logic [LEN_W-1:0]     hdr_len;
    logic                 body_valid;
    logic                 body_ready;
    logic [DATA_W-1:0]    body_data;
    logic                 flit_valid;
    logic                 flit_ready;
    flit_type_t           flit_type;
    logic [DATA_W-1:0]    flit_data;

    modport master (
        input  hdr_valid, hdr_dst, hdr_len,
        output hdr_ready,
        input  body_valid, body_data,
        output body_ready,
        output flit_valid, flit_type, flit_data,
        input  flit_ready
    );

    modport slave (
        output hdr_valid, hdr_dst, hdr_len,
        input  hdr_ready,
        output body_valid, body_data,
        input  body_ready,
        input  flit_valid, flit_type, flit_data,
        output flit_ready
    );
endinterface

// File: rtl/noc_flit_tx.sv
// Packet injector: HEAD, BODY*len, TAIL(xor checksum) through a single
// output register that only reloads when the router has taken its flit.
module noc_flit_tx
    import noc_flit_tx_pkg::*;
#(
    parameter int DATA_W    = noc_flit_tx_pkg::DATA_W,
    parameter int NODE_ID_W = noc_flit_tx_pkg::NODE_ID_W,
    parameter int LEN_W     = noc_flit_tx_pkg::LEN_W,
    parameter int SEQ_W     = noc_flit_tx_pkg::SEQ_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NODE_ID_W-1:0] node_id,
    output logic                 busy,
    noc_flit_tx_if.master        lnk
);

    tx_state_t         state_q, state_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic [DATA_W-1:0] csum_q, csum_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              fv_q, fv_d;
    flit_type_t        ft_q, ft_d;
    logic [DATA_W-1:0] fd_q, fd_d;
    logic              slot_free;
    logic              hdr_rdy;
    logic              body_rdy;

    assign slot_free = !fv_q || lnk.flit_ready;

    always_comb begin
        state_d  = state_q;
        seq_d    = seq_q;
        csum_d   = csum_q;
        rem_d    = rem_q;
        fv_d     = fv_q && !lnk.flit_ready;
        ft_d     = ft_q;
        fd_d     = fd_q;
        hdr_rdy  = 1'b0;
        body_rdy = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                hdr_rdy = slot_free;
                if (lnk.hdr_valid && slot_free) begin
                    fv_d = 1'b1;
                    ft_d = FLIT_HEAD;
                    fd_d = '0;
                    fd_d[HEAD_DST_LSB +: NODE_ID_W] = lnk.hdr_dst;
                    fd_d[HEAD_SRC_LSB +: NODE_ID_W] = node_id;
                    fd_d[HEAD_LEN_LSB +: LEN_W]     = lnk.hdr_len;
                    fd_d[HEAD_SEQ_LSB +: SEQ_W]     = seq_q;
                    rem_d   = lnk.hdr_len;
                    csum_d  = '0;
                    seq_d   = seq_q + SEQ_W'(1);
                    state_d = (lnk.hdr_len != '0) ? S_BODY : S_TAIL;
                end
            end
            S_BODY: begin
                body_rdy = slot_free;
                if (lnk.body_valid && slot_free) begin
                    fv_d   = 1'b1;
                    ft_d   = FLIT_BODY;
                    fd_d   = lnk.body_data;
                    csum_d = csum_q ^ lnk.body_data;
                    rem_d  = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) state_d = S_TAIL;
                end
            end
            S_TAIL: begin
                if (slot_free) begin
                    fv_d    = 1'b1;
                    ft_d    = FLIT_TAIL;
                    fd_d    = csum_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            seq_q   <= '0;
            csum_q  <= '0;
            rem_q   <= '0;
            fv_q    <= 1'b0;
            ft_q    <= FLIT_HEAD;
            fd_q    <= '0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            csum_q  <= csum_d;
            rem_q   <= rem_d;
            fv_q    <= fv_d;
            ft_q    <= ft_d;
            fd_q    <= fd_d;
        end
    end

    assign lnk.hdr_ready  = hdr_rdy;
    assign lnk.body_ready = body_rdy;
    assign lnk.flit_valid = fv_q;
    assign lnk.flit_type  = ft_q;
    assign lnk.flit_data  = fd_q;
    assign busy           = (state_q != S_IDLE) || fv_q;

endmodule

// File: tb/tb_noc_flit_tx.sv
// Randomized bench for noc_flit_tx against a packet-level flit queue model.
module tb_noc_flit_tx;
    import noc_flit_tx_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] node_id = 8'h00;
    logic       busy;

    noc_flit_tx_if u_if ();

    noc_flit_tx u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .node_id (node_id),
        .busy    (busy),
        .lnk     (u_if)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int errs  = 0;
    int cyc   = 0;
    int rmode = 0;
    int brdy_cnt = 0;

    logic [33:0] expq[$];
    logic [33:0] log_f[$];
    int          log_c[$];
    logic [7:0]  mseq = 8'h00;
    logic [31:0] bw[16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        tests++;
        errs++;
        $display("FAIL %s timeout", nm);
    endtask

    // flit_ready generator: 0=always, 1=random, 2=pattern 1,0,0,1
    initial begin
        logic [3:0] pat;
        int pidx;
        pat = 4'b1001;
        pidx = 0;
        u_if.flit_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                1: u_if.flit_ready = 1'($urandom_range(0, 1));
                2: begin
                    u_if.flit_ready = pat[pidx[1:0]];
                    pidx++;
                end
                default: u_if.flit_ready = 1'b1;
            endcase
        end
    end

    // per-cycle checker: transfers against the model, hold during stalls
    logic        stall_q = 1'b0;
    logic [33:0] prev_f = '0;
    always @(negedge clk) begin
        logic [33:0] cur;
        logic [33:0] e;
        cur = {u_if.flit_type, u_if.flit_data};
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            chk("rdy_exclusive", {63'd0, u_if.hdr_ready & u_if.body_ready},
                64'd0);
            if (u_if.body_ready) brdy_cnt++;
            if (stall_q) begin
                chk("stall_hold", {29'd0, u_if.flit_valid, cur},
                    {29'd0, 1'b1, prev_f});
            end
            if (u_if.flit_valid && u_if.flit_ready) begin
                if (expq.size() == 0) begin
                    tmo("unexpected_flit");
                end else begin
                    e = expq.pop_front();
                    chk("flit", {30'd0, cur}, {30'd0, e});
                end
                log_f.push_back(cur);
                log_c.push_back(cyc);
            end
            stall_q = u_if.flit_valid && !u_if.flit_ready;
            prev_f  = cur;
        end
    end

    function automatic logic [31:0] head_of(input logic [7:0] dst,
        input logic [7:0] src, input logic [3:0] len, input logic [7:0] sq);
        return ({24'd0, sq} << 20) | ({28'd0, len} << 16) |
               ({24'd0, src} << 8) | {24'd0, dst};
    endfunction

    task automatic wait_hdr();
        int n;
        logic acc;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 500) begin
            @(negedge clk);
            acc = u_if.hdr_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) tmo("hdr_accept");
    endtask

    task automatic wait_body();
        int n;
        logic acc;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 500) begin
            @(negedge clk);
            acc = u_if.body_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) tmo("body_accept");
    endtask

    // bodies come from bw[]; the model queue holds the whole packet
    task automatic send_pkt(input logic [7:0] dst, input logic [3:0] len,
                            input bit gaps);
        logic [31:0] cs;
        cs = '0;
        expq.push_back({FLIT_HEAD, head_of(dst, node_id, len, mseq)});
        for (int i = 0; i < int'(len); i++) begin
            expq.push_back({FLIT_BODY, bw[i]});
            cs = cs ^ bw[i];
        end
        expq.push_back({FLIT_TAIL, cs});
        mseq = mseq + 8'd1;
        u_if.hdr_valid = 1'b1;
        u_if.hdr_dst   = dst;
        u_if.hdr_len   = len;
        wait_hdr();
        u_if.hdr_valid = 1'b0;
        u_if.hdr_dst   = 8'($urandom);
        for (int i = 0; i < int'(len); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            u_if.body_valid = 1'b1;
            u_if.body_data  = bw[i];
            wait_body();
            u_if.body_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((expq.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) tmo("drain");
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        expq.delete();
        mseq = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int b0;
        u_if.hdr_valid  = 1'b0;
        u_if.hdr_dst    = '0;
        u_if.hdr_len    = '0;
        u_if.body_valid = 1'b0;
        u_if.body_data  = '0;
        do_reset();

        @(negedge clk);
        chk("rst_flit_valid", {63'd0, u_if.flit_valid}, 64'd0);
        chk("rst_hdr_ready", {63'd0, u_if.hdr_ready}, 64'd1);
        chk("rst_body_ready", {63'd0, u_if.body_ready}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_flit", {30'd0, u_if.flit_type, u_if.flit_data}, 64'd0);
        @(posedge clk);
        #1;

        // directed len=2 packet with literal flits
        node_id = 8'h03;
        rmode = 0;
        base = log_f.size();
        bw[0] = 32'hA5A5A5A5;
        bw[1] = 32'h0F0F0F0F;
        send_pkt(8'h05, 4'd2, 1'b0);
        drain();
        if (log_f.size() >= base + 4) begin
            chk("lit_head", {30'd0, log_f[base]}, {30'd0, 2'd0, 32'h00020305});
            chk("lit_body0", {30'd0, log_f[base+1]}, {30'd1, 32'hA5A5A5A5});
            chk("lit_body1", {30'd0, log_f[base+2]}, {30'd1, 32'h0F0F0F0F});
            chk("lit_tail", {30'd0, log_f[base+3]}, {30'd2, 32'hAAAAAAAA});
            for (int i = 0; i < 3; i++)
                chk("lit_consec", 64'(log_c[base+i+1] - log_c[base+i]), 64'd1);
        end else tmo("lit_count");

        // len=0: HEAD then zero TAIL, body_ready never rises
        base = log_f.size();
        b0 = brdy_cnt;
        send_pkt(8'h07, 4'd0, 1'b0);
        drain();
        if (log_f.size() >= base + 2) begin
            chk("len0_head", {30'd0, log_f[base]}, {30'd0, 2'd0, 32'h00100307});
            chk("len0_tail", {30'd0, log_f[base+1]}, {30'd2, 32'h0});
        end else tmo("len0_count");
        chk("len0_no_body_ready", 64'(brdy_cnt - b0), 64'd0);

        // len=3 under a 1,0,0,1 ready pattern
        rmode = 2;
        base = log_f.size();
        bw[0] = 32'h1;
        bw[1] = 32'h2;
        bw[2] = 32'h4;
        send_pkt(8'h09, 4'd3, 1'b0);
        drain();
        if (log_f.size() >= base + 5)
            chk("stall_tail", {30'd0, log_f[base+4]}, {30'd2, 32'h7});
        else tmo("stall_count");
        chk("stall_count", 64'(log_f.size() - base), 64'd5);

        // randomized packets
        rmode = 1;
        for (int p = 0; p < 40; p++) begin
            logic [7:0] d;
            node_id = 8'($urandom);
            d = ($urandom_range(0, 3) == 0) ? node_id : 8'($urandom);
            for (int i = 0; i < 16; i++) bw[i] = $urandom;
            send_pkt(d, 4'($urandom_range(0, 15)), 1'b1);
        end
        drain();

        // 257 back-to-back len=0 packets: seq 0..255 then 0
        do_reset();
        rmode = 0;
        base = log_f.size();
        for (int k = 0; k < 257; k++) send_pkt(8'($urandom), 4'd0, 1'b0);
        drain();
        if (log_f.size() >= base + 514) begin
            for (int k = 0; k < 257; k++) begin
                chk("wrap_seq", {56'd0, log_f[base+2*k][27:20]},
                    64'(k % 256));
                if (k < 256)
                    chk("wrap_gap", 64'(log_c[base+2*k+2] - log_c[base+2*k]),
                        64'd2);
            end
        end else tmo("wrap_count");

        // reset with a BODY flit sitting in the output register
        u_if.hdr_valid = 1'b1;
        u_if.hdr_dst   = 8'h11;
        u_if.hdr_len   = 4'd3;
        expq.push_back({FLIT_HEAD, head_of(8'h11, node_id, 4'd3, mseq)});
        wait_hdr();
        u_if.hdr_valid  = 1'b0;
        u_if.body_valid = 1'b1;
        u_if.body_data  = 32'hDEADBEEF;
        wait_body();
        u_if.body_valid = 1'b0;
        chk("mid_body_loaded", {61'd0, u_if.flit_valid, u_if.flit_type},
            {61'd0, 1'b1, 2'd1});
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {63'd0, u_if.flit_valid}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        expq.delete();
        mseq = 8'h00;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        base = log_f.size();
        bw[0] = 32'h12345678;
        send_pkt(8'h22, 4'd1, 1'b0);
        drain();
        if (log_f.size() >= base + 3) begin
            chk("post_rst_seq", {56'd0, log_f[base][27:20]}, 64'd0);
            chk("post_rst_tail", {30'd0, log_f[base+2]},
                {30'd2, 32'h12345678});
        end else tmo("post_rst_count");

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
